clock_dff_seq_det: RTL and testbench

- Button-stepped serial sequence detector for the FPGA lab board.
- SWITCH is a mechanical step button. It is synchronized, debounced on a divided tick, and each debounced rising edge shifts one bit of serial input `code` into a history register.
- `detected` asserts while the most recent bits equal the target pattern.
- NEW_CLK is the divided slow clock, brought out for an LED/probe. It is not used as a clock internally; all logic runs on CLK.

---
 rtl/clock_dff_seq_det.sv | 128 ++++++++++++
 tb/tb_clock_dff_seq_det.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_dff_seq_det.sv
// clock_dff_seq_det
//   Button-stepped serial sequence detector for the lab board. A mechanical
//   step button (SWITCH) is synchronized and debounced on a divided tick.
//   Each debounced press shifts one synchronized bit of `code` into a
//   history register. `detected` is high while the last SEQ_LEN stepped
//   bits equal SEQ (MSB = oldest bit).
//
// Parameters
//   DIV      CLK cycles per tick (1..65536)
//   DEB      ticks a new switch level must persist before it is accepted (1..255)
//   SEQ_LEN  pattern length in bits (2..16)
//   SEQ      target pattern, MSB oldest
//
// Ports
//   CLK       in   system clock, every flop on its rising edge
//   RST       in   synchronous reset, active-high
//   SWITCH    in   raw asynchronous step button
//   code      in   asynchronous serial data bit
//   detected  out  registered match flag, updated only on a step
//   NEW_CLK   out  registered divided clock, toggles each tick (period 2*DIV)
module clock_dff_seq_det #(
  parameter int unsigned        DIV     = 1,
  parameter int unsigned        DEB     = 1,
  parameter int unsigned        SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1011
) (
  input  logic CLK,
  input  logic RST,
  input  logic SWITCH,
  input  logic code,
  output logic detected,
  output logic NEW_CLK
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FW = $clog2(SEQ_LEN + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [7:0]    DEB_CNT   = 8'(DEB);
  localparam logic [FW-1:0] FILL_FULL = FW'(SEQ_LEN);

  logic [CW-1:0]      tick_cnt;
  logic               tick;
  logic               s1_switch, s2_switch;
  logic               s1_code, s2_code;
  logic [7:0]         deb_cnt;
  logic [7:0]         deb_cnt_inc;
  logic               deb, deb_q;
  logic               step;
  logic [SEQ_LEN-1:0] hist;
  logic [SEQ_LEN-1:0] hist_next;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_next;

  // With DIV=1 the counter is pinned at 0 and tick is high every cycle.
  assign tick = (tick_cnt == DIV_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt <= '0;
      NEW_CLK  <= 1'b0;
    end else if (tick) begin
      tick_cnt <= '0;
      NEW_CLK  <= ~NEW_CLK;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_switch <= 1'b0;
      s2_switch <= 1'b0;
      s1_code   <= 1'b0;
      s2_code   <= 1'b0;
    end else begin
      s1_switch <= SWITCH;
      s2_switch <= s1_switch;
      s1_code   <= code;
      s2_code   <= s1_code;
    end
  end

  // The count only advances while the synchronized level disagrees with deb;
  // any tick where they agree restarts the qualification.
  assign deb_cnt_inc = deb_cnt + 8'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_cnt <= '0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
    end else begin
      deb_q <= deb;
      if (tick) begin
        if (s2_switch != deb) begin
          if (deb_cnt_inc == DEB_CNT) begin
            deb     <= s2_switch;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt_inc;
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  end

  assign step      = deb & ~deb_q;
  assign hist_next = {hist[SEQ_LEN-2:0], s2_code};
  assign fill_next = (fill == FILL_FULL) ? fill : fill + FW'(1);

  // The fill count keeps a match from being reported before SEQ_LEN real
  // bits have been stepped in since reset (matters for all-zero patterns).
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (step) begin
      hist     <= hist_next;
      fill     <= fill_next;
      detected <= (hist_next == SEQ) && (fill_next == FILL_FULL);
    end
  end

endmodule

// File: tb/tb_clock_dff_seq_det.sv
module tb_clock_dff_seq_det;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sw = 1'b0;
  logic code = 1'b0;
  logic det_a, nclk_a, det_b, nclk_b, det_z, nclk_z;

  // Defaults: DIV=1, DEB=1, SEQ=1011
  clock_dff_seq_det #(.DIV(1), .DEB(1), .SEQ_LEN(4), .SEQ(4'b1011)) dut_a (
    .CLK(clk), .RST(rst), .SWITCH(sw), .code(code),
    .detected(det_a), .NEW_CLK(nclk_a)
  );

  // Slow tick with a real debounce window
  clock_dff_seq_det #(.DIV(4), .DEB(3), .SEQ_LEN(4), .SEQ(4'b1011)) dut_b (
    .CLK(clk), .RST(rst), .SWITCH(sw), .code(code),
    .detected(det_b), .NEW_CLK(nclk_b)
  );

  // All-zero pattern to exercise the fill guard
  clock_dff_seq_det #(.DIV(1), .DEB(1), .SEQ_LEN(4), .SEQ(4'b0000)) dut_z (
    .CLK(clk), .RST(rst), .SWITCH(sw), .code(code),
    .detected(det_z), .NEW_CLK(nclk_z)
  );

  typedef struct packed {
    bit code;
    bit exp;
  } vec_t;

  vec_t tbl[$];
  bit   steps[$];
  bit   last_exp;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic get_det(input int sel);
    case (sel)
      0:       return det_a;
      1:       return det_b;
      default: return det_z;
    endcase
  endfunction

  // Reference: match if at least 4 bits stepped since reset and the last
  // four (oldest first) read as the pattern value.
  function automatic bit model_det(input int pattern);
    int v;
    if (steps.size() < 4) return 1'b0;
    v = 0;
    for (int i = steps.size() - 4; i < steps.size(); i++) v = v * 2 + int'(steps[i]);
    return v == pattern;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    sw  = 1'b0;
    cyc(n);
    rst = 1'b0;
    steps.delete();
    last_exp = 1'b0;
    cyc(2);
  endtask

  // One press for the DIV=1/DEB=1 instances. The edge sampling SWITCH=1 is
  // k; detected must still hold its old value after k+2 and update at k+3.
  task automatic step(input int sel, input bit b, input bit exp_new, input string name);
    code = b;
    sw   = 1'b0;
    cyc(2);
    sw = 1'b1;
    cyc(2);
    sw = 1'b0;
    cyc(1);
    check({name, "_hold"}, get_det(sel), last_exp);
    cyc(1);
    check(name, get_det(sel), exp_new);
    last_exp = exp_new;
    cyc(1);
  endtask

  task automatic mstep(input int sel, input bit b, input int pattern, input string name);
    steps.push_back(b);
    step(sel, b, model_det(pattern), name);
  endtask

  task automatic run_table(input string name, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      steps.push_back(tbl[i].code);
      step(0, tbl[i].code, tbl[i].exp, $sformatf("%s[%0d]", name, i - first));
    end
  endtask

  task automatic load(input bit [31:0] bits, input bit [31:0] exps, input int n);
    vec_t v;
    for (int i = n - 1; i >= 0; i--) begin
      v.code = bits[i];
      v.exp  = exps[i];
      tbl.push_back(v);
    end
  endtask

  // Press for the DIV=4/DEB=3 instance; hi is the SWITCH high time in CLK.
  task automatic press_b(input bit b, input int hi);
    code = b;
    sw   = 1'b0;
    cyc(4);
    sw = 1'b1;
    cyc(hi);
    sw = 1'b0;
    cyc(24);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // tables: basic 0..3, overlap 4..10, stream 11..28
    load(32'b1011, 32'b0001, 4);
    load(32'b1011011, 32'b0001001, 7);
    load(32'b101010111000110101, 32'b000000010000000000, 18);

    do_reset(3);
    check("reset_det", det_a, 1'b0);
    check("reset_nclk", nclk_a, 1'b0);

    run_table("basic", 0, 4);
    cyc(10);
    check("basic_stays", det_a, 1'b1);

    // Reset held 3 cycles with SWITCH toggling and code high
    rst  = 1'b1;
    code = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw = ~sw;
      cyc(1);
      check($sformatf("rst_det[%0d]", i), det_a, 1'b0);
      check($sformatf("rst_nclk_a[%0d]", i), nclk_a, 1'b0);
      check($sformatf("rst_nclk_b[%0d]", i), nclk_b, 1'b0);
    end
    sw  = 1'b0;
    rst = 1'b0;
    steps.delete();
    last_exp = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      cyc(1);
      check($sformatf("nclk_a[%0d]", n), nclk_a, logic'(n % 2));
      check($sformatf("nclk_z[%0d]", n), nclk_z, logic'(n % 2));
      check($sformatf("nclk_b[%0d]", n), nclk_b, logic'((n / 4) % 2));
    end

    run_table("overlap", 4, 7);

    do_reset(2);
    run_table("stream", 11, 18);

    // Reset mid-sequence
    do_reset(2);
    mstep(0, 1'b1, 11, "mid_a");
    mstep(0, 1'b0, 11, "mid_b");
    mstep(0, 1'b1, 11, "mid_c");
    do_reset(1);
    mstep(0, 1'b1, 11, "mid_d");
    mstep(0, 1'b0, 11, "mid_e");
    mstep(0, 1'b1, 11, "mid_f");
    mstep(0, 1'b1, 11, "mid_g");

    // Reset landing on the very edge that would have completed 1011
    do_reset(2);
    mstep(0, 1'b1, 11, "rw_a");
    mstep(0, 1'b0, 11, "rw_b");
    mstep(0, 1'b1, 11, "rw_c");
    code = 1'b1;
    sw   = 1'b0;
    cyc(2);
    sw = 1'b1;
    cyc(2);
    sw = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_wins", det_a, 1'b0);
    steps.delete();
    last_exp = 1'b0;
    cyc(2);
    mstep(0, 1'b1, 11, "rw_d");
    mstep(0, 1'b0, 11, "rw_e");
    mstep(0, 1'b1, 11, "rw_f");
    mstep(0, 1'b1, 11, "rw_g");

    // Fill guard with an all-zero pattern
    do_reset(2);
    for (int i = 0; i < 4; i++) mstep(2, 1'b0, 0, $sformatf("fill[%0d]", i));

    // Random stream against the reference model
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      mstep(0, 1'($urandom_range(0, 1)), 11, $sformatf("rnd[%0d]", i));
      check($sformatf("rnd_z[%0d]", i), det_z, logic'(model_det(0)));
    end

    // Debounce on the DIV=4, DEB=3 instance
    do_reset(2);
    press_b(1'b1, 24);
    check("deb_s1", det_b, 1'b0);
    press_b(1'b0, 24);
    check("deb_s2", det_b, 1'b0);
    press_b(1'b1, 24);
    check("deb_s3", det_b, 1'b0);
    press_b(1'b1, 8);
    check("deb_glitch", det_b, 1'b0);
    press_b(1'b1, 24);
    check("deb_after_glitch", det_b, 1'b1);
    press_b(1'b0, 80);
    check("deb_long_hold", det_b, 1'b0);
    press_b(1'b1, 24);
    check("deb_l1", det_b, 1'b0);
    press_b(1'b1, 24);
    check("deb_l2", det_b, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
